// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, start + DATA_WIDTH data (LSB first) + stop.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
   parameter int CLK_RATE_MHz = 100,
   parameter int DATA_WIDTH   = 8,
   parameter int BAUDRATE     = 9600
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic                  in_en,
   input  logic                  in_rx,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_busy,
   output logic                  out_frame_err,
   output logic                  out_parity_err
);

   localparam int M     = CLK_RATE_MHz * 1000000 / BAUDRATE;
   localparam int HALF  = M / 2;
   localparam int CNT_W = $clog2(M + 1);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic                  rx_meta;
   logic                  rx_s;
   logic [2:0]            state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
   logic                  par_bad_q;
`endif

   // Two-flop synchroniser; free-running so the line is tracked even when disabled.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= in_rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM: start validation, mid-bit sampling, stop check and output pulses.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         shift_q       <= '0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         out_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q     <= 1'b0;
         out_parity_err <= 1'b0;
`endif
      end else if (in_en) begin
         out_valid     <= 1'b0;
         out_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         out_parity_err <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  state_q <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  shift_q[idx_q] <= rx_s;
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q     <= '0;
                  par_bad_q <= ^{shift_q, rx_s};
                  state_q   <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     out_data  <= shift_q;
                     out_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     out_parity_err <= par_bad_q;
`endif
                     state_q <= S_IDLE;
                  end else begin
                     out_frame_err <= 1'b1;
                     state_q <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               cnt_q <= '0;
               if (rx_s) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   // Without a parity bit there is nothing to flag.
   assign out_parity_err = 1'b0;
`endif

   // Busy whenever a frame (or a held-low line) is being tracked.
   assign out_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level reference model.
// Honours UART_RX_PARITY_EN so the same bench covers both builds.
module tb_uart_rx;

   localparam int CLK_MHZ = 1;
   localparam int BAUD    = 100000;
   localparam int DW      = 8;
   localparam int M       = CLK_MHZ * 1000000 / BAUD;
   localparam int HALF    = M / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   // sync delay + every bit before stop + half of the stop bit
   localparam int LAT = 2 + (1 + DW + PBITS) * M + HALF;

   logic          in_clk = 1'b0;
   logic          in_rst_n;
   logic          in_en;
   logic          in_rx;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_busy;
   logic          out_frame_err;
   logic          out_parity_err;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [DW-1:0] exp_dat_q[$];
   int            exp_cyc_q[$];
   bit            exp_per_q[$];
   int            exp_fe_q[$];
   logic [DW-1:0] rec_dat_q[$];
   int            rec_cyc_q[$];
   bit            rec_per_q[$];
   int            rec_fe_q[$];
   int            stray_per = 0;

   uart_rx #(
      .CLK_RATE_MHz(CLK_MHZ),
      .DATA_WIDTH  (DW),
      .BAUDRATE    (BAUD)
   ) dut (
      .in_clk        (in_clk),
      .in_rst_n      (in_rst_n),
      .in_en         (in_en),
      .in_rx         (in_rx),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_busy      (out_busy),
      .out_frame_err (out_frame_err),
      .out_parity_err(out_parity_err)
   );

   always #5 in_clk = ~in_clk;

   always @(posedge in_clk) cyc <= cyc + 1;

   // record every pulse consumed by an enabled edge
   always @(negedge in_clk) begin
      if (in_en) begin
         if (out_valid) begin
            rec_dat_q.push_back(out_data);
            rec_cyc_q.push_back(cyc);
            rec_per_q.push_back(out_parity_err);
         end else if (out_parity_err) begin
            stray_per++;
         end
         if (out_frame_err) rec_fe_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge in_clk);
         #2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input bit stop,
                             input bit pflip, input int stop_ticks,
                             input int extra, input bit expect_it);
      int e0;
      e0 = cyc + 1;
      in_rx = 1'b0;
      tick(M);
      for (int i = 0; i < DW; i++) begin
         in_rx = d[i];
         tick(M);
      end
`ifdef UART_RX_PARITY_EN
      in_rx = (^d) ^ pflip;
      tick(M);
`endif
      in_rx = stop;
      tick(stop_ticks);
      if (expect_it) begin
         if (stop) begin
            exp_dat_q.push_back(d);
            exp_cyc_q.push_back(e0 + LAT + extra);
            exp_per_q.push_back(pflip && (PBITS == 1));
         end else begin
            exp_fe_q.push_back(e0 + LAT + extra);
         end
      end
   endtask

   task automatic verify(input string tag);
      chk({tag, "/words"}, rec_dat_q.size(), exp_dat_q.size());
      for (int i = 0; i < exp_dat_q.size() && i < rec_dat_q.size(); i++) begin
         chk({tag, "/data"}, rec_dat_q[i], exp_dat_q[i]);
         chk({tag, "/cycle"}, rec_cyc_q[i], exp_cyc_q[i]);
         chk({tag, "/perr"}, rec_per_q[i], exp_per_q[i]);
      end
      chk({tag, "/ferrs"}, rec_fe_q.size(), exp_fe_q.size());
      for (int i = 0; i < exp_fe_q.size() && i < rec_fe_q.size(); i++) begin
         chk({tag, "/ferr_cycle"}, rec_fe_q[i], exp_fe_q[i]);
      end
      chk({tag, "/stray_perr"}, stray_per, 0);
      exp_dat_q.delete();
      exp_cyc_q.delete();
      exp_per_q.delete();
      exp_fe_q.delete();
      rec_dat_q.delete();
      rec_cyc_q.delete();
      rec_per_q.delete();
      rec_fe_q.delete();
      stray_per = 0;
   endtask

   initial begin
      bit found;
      in_rst_n = 1'b0;
      in_en    = 1'b1;
      in_rx    = 1'b1;
      tick(2);
      chk("reset/data", out_data, 0);
      chk("reset/valid", out_valid, 0);
      chk("reset/busy", out_busy, 0);
      chk("reset/ferr", out_frame_err, 0);
      chk("reset/perr", out_parity_err, 0);
      in_rst_n = 1'b1;
      tick(3);

      send_frame(8'hA5, 1'b1, 1'b0, M, 0, 1'b1);
      verify("a5");
      chk("a5/out_data", out_data, 8'hA5);

      in_rx = 1'b0;
      tick(3);
      chk("glitch/busy_hi", out_busy, 1);
      in_rx = 1'b1;
      tick(5);
      chk("glitch/busy_lo", out_busy, 0);
      tick(M);
      verify("glitch");

      send_frame(8'h3C, 1'b0, 1'b0, M, 0, 1'b1);
      tick(30);
      chk("break/busy", out_busy, 1);
      chk("break/data_kept", out_data, 8'hA5);
      verify("break");
      in_rx = 1'b1;
      tick(4);
      chk("break/released", out_busy, 0);
      send_frame(8'h81, 1'b1, 1'b0, M, 0, 1'b1);
      verify("after_break");

      send_frame(8'h00, 1'b1, 1'b0, M, 0, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b0, M, 0, 1'b1);
      send_frame(8'h55, 1'b1, 1'b0, M, 0, 1'b1);
      verify("b2b");

      in_rx = 1'b0;
      tick(M);
      for (int i = 0; i < 3; i++) begin
         in_rx = (i == 1);
         tick(M);
      end
      chk("rst/busy_mid", out_busy, 1);
      in_rst_n = 1'b0;
      #1;
      chk("rst/data", out_data, 0);
      chk("rst/valid", out_valid, 0);
      chk("rst/busy", out_busy, 0);
      chk("rst/ferr", out_frame_err, 0);
      tick(2);
      in_rx = 1'b1;
      tick(3);
      in_rst_n = 1'b1;
      tick(3);
      send_frame(8'h34, 1'b1, 1'b0, M, 0, 1'b1);
      verify("rst");

      send_frame(8'h07, 1'b1, 1'b0, M, 0, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1, M, 0, 1'b1);
      verify("parity");

      in_en = 1'b0;
      send_frame(8'h77, 1'b1, 1'b0, M, 0, 1'b0);
      tick(2);
      chk("frozen/busy", out_busy, 0);
      in_en = 1'b1;
      tick(M);
      chk("frozen/busy_en", out_busy, 0);
      chk("frozen/data", out_data, 8'h07);
      verify("frozen");

      send_frame(8'h5A, 1'b1, 1'b0, 0, 3, 1'b1);
      found = 1'b0;
      for (int k = 0; k < 2 * M && !found; k++) begin
         if (out_valid) found = 1'b1;
         else tick(1);
      end
      chk("hold/seen", found, 1);
      in_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("hold/valid_held", out_valid, 1);
      end
      in_en = 1'b1;
      tick(1);
      chk("hold/valid_done", out_valid, 0);
      tick(M);
      verify("hold");

      for (int r = 0; r < 8; r++) begin
         send_frame(DW'($urandom), 1'b1, 1'($urandom_range(0, 1)), M, 0, 1'b1);
         tick($urandom_range(0, 12));
      end
      tick(M);
      verify("random");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
